// File: rtl/dense_sequencer_if.sv
// Handshake and layer-control bundle for dense_sequencer.
//   master : sequencer side (drives img_ready, layer enables/clear, digit, status)
//   slave  : environment side (drives img_valid, layer dones, scores, digit_ready)
// Class i of l2_scores occupies bits [i*DATA_W +: DATA_W].
interface dense_sequencer_if #(
  parameter int unsigned N_CLASS = 10,
  parameter int unsigned DATA_W  = 16
);
  logic                      img_valid;
  logic                      img_ready;
  logic                      l1_enable;
  logic                      l1_done;
  logic                      l2_enable;
  logic                      l2_done;
  logic                      layer_clear;
  logic [N_CLASS*DATA_W-1:0] l2_scores;
  logic [3:0]                digit;
  logic                      digit_valid;
  logic                      digit_ready;
  logic                      busy;
  logic                      timeout;

  modport master (
    input  img_valid, l1_done, l2_done, l2_scores, digit_ready,
    output img_ready, l1_enable, l2_enable, layer_clear, digit, digit_valid, busy, timeout
  );

  modport slave (
    output img_valid, l1_done, l2_done, l2_scores, digit_ready,
    input  img_ready, l1_enable, l2_enable, layer_clear, digit, digit_valid, busy, timeout
  );
endinterface

// File: rtl/dense_sequencer.sv
// Control FSM for the fully connected stage of the digit classifier.
// Accepts one pooled image, runs dense layer 1 then layer 2, serially arg-maxes the
// layer-2 scores into a 4-bit digit, hands it downstream, then clears both layers.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset (state CLEAR while low)
//   bus   : dense_sequencer_if.master (image/digit handshakes, layer control, status)
// Optional feature: define DENSE_SEQ_TIMEOUT_EN to build a per-layer-run watchdog of
// TIMEOUT_CYCLES cycles; otherwise run states wait forever and timeout is tied low.
// All outputs are registered and decoded from the next state.
module dense_sequencer #(
  parameter int unsigned N_CLASS        = 10,
  parameter int unsigned DATA_W         = 16,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input logic                clk,
  input logic                reset,
  dense_sequencer_if.master  bus
);

  typedef enum logic [2:0] {StClear, StIdle, StL1Run, StL2Run, StArgmax, StOut} state_e;

  state_e                    state_q, state_d;
  logic [3:0]                idx_q, idx_d;
  logic [3:0]                best_q, best_d;
  logic signed [DATA_W-1:0]  max_q, max_d;
  logic [3:0]                digit_q, digit_d;
  logic                      img_ready_q, img_ready_d;
  logic                      l1_enable_q, l1_enable_d;
  logic                      l2_enable_q, l2_enable_d;
  logic                      layer_clear_q, layer_clear_d;
  logic                      digit_valid_q, digit_valid_d;
  logic                      busy_q, busy_d;
  logic                      timeout_q, timeout_d;
  logic signed [DATA_W-1:0]  score;
  logic                      take;
  logic                      tmo_hit;

  // Score under the argmax pointer; layers are held enabled so scores are stable.
  assign score = bus.l2_scores[idx_q*DATA_W +: DATA_W];
  // Strict signed compare: ties keep the lower index. Score 0 always seeds the max.
  assign take  = (idx_q == 4'd0) || (score > max_q);

`ifdef DENSE_SEQ_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;

  assign tmo_hit = (tmo_cnt_q == TmoW'(TIMEOUT_CYCLES - 1));

  // Counts cycles spent in the current run state; any state change zeroes it.
  always_comb begin
    tmo_cnt_d = '0;
    if ((state_d == state_q) && (state_q inside {StL1Run, StL2Run})) begin
      tmo_cnt_d = tmo_cnt_q + TmoW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tmo_cnt_q <= '0;
    else        tmo_cnt_q <= tmo_cnt_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    best_d    = best_q;
    max_d     = max_q;
    digit_d   = digit_q;
    timeout_d = 1'b0;
    unique case (state_q)
      StClear: state_d = StIdle;
      StIdle: begin
        if (bus.img_valid) state_d = StL1Run;
      end
      StL1Run: begin
        if (bus.l1_done) begin
          state_d = StL2Run;
        end else if (tmo_hit) begin
          state_d   = StClear;
          timeout_d = 1'b1;
        end
      end
      StL2Run: begin
        if (bus.l2_done) begin
          state_d = StArgmax;
          idx_d   = 4'd0;
        end else if (tmo_hit) begin
          state_d   = StClear;
          timeout_d = 1'b1;
        end
      end
      StArgmax: begin
        if (take) begin
          max_d  = score;
          best_d = idx_q;
        end
        if (idx_q == 4'(N_CLASS - 1)) begin
          digit_d = take ? idx_q : best_q;
          state_d = StOut;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      StOut: begin
        if (bus.digit_ready) state_d = StClear;
      end
      default: state_d = StClear;
    endcase

    // Moore decode of the next state so every output is a flop.
    img_ready_d   = (state_d == StIdle);
    l1_enable_d   = (state_d inside {StL1Run, StL2Run, StArgmax});
    l2_enable_d   = (state_d inside {StL2Run, StArgmax});
    layer_clear_d = (state_d == StClear);
    digit_valid_d = (state_d == StOut);
    busy_d        = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StClear;
      idx_q         <= '0;
      best_q        <= '0;
      max_q         <= '0;
      digit_q       <= '0;
      img_ready_q   <= 1'b0;
      l1_enable_q   <= 1'b0;
      l2_enable_q   <= 1'b0;
      layer_clear_q <= 1'b1;
      digit_valid_q <= 1'b0;
      busy_q        <= 1'b1;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      best_q        <= best_d;
      max_q         <= max_d;
      digit_q       <= digit_d;
      img_ready_q   <= img_ready_d;
      l1_enable_q   <= l1_enable_d;
      l2_enable_q   <= l2_enable_d;
      layer_clear_q <= layer_clear_d;
      digit_valid_q <= digit_valid_d;
      busy_q        <= busy_d;
      timeout_q     <= timeout_d;
    end
  end

  assign bus.img_ready   = img_ready_q;
  assign bus.l1_enable   = l1_enable_q;
  assign bus.l2_enable   = l2_enable_q;
  assign bus.layer_clear = layer_clear_q;
  assign bus.digit       = digit_q;
  assign bus.digit_valid = digit_valid_q;
  assign bus.busy        = busy_q;
  assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_dense_sequencer.sv
// Bench for dense_sequencer: directed score vectors with hand-computed winners.
// Expected digits are queued when an image is issued; a monitor pops and compares on
// every digit handshake. Inputs are driven 1 time unit after the rising edge.
module tb_dense_sequencer;
  localparam int unsigned NC = 10;
  localparam int unsigned DW = 16;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [3:0] exp_q[$];

  dense_sequencer_if #(.N_CLASS(NC), .DATA_W(DW)) bus ();

  dense_sequencer #(
    .N_CLASS        (NC),
    .DATA_W         (DW),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: one compare per accepted digit.
  always @(negedge clk) begin
    if (reset && bus.digit_valid && bus.digit_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_digit", {28'd0, bus.digit}, 32'hffff_ffff);
      end else begin
        chk("digit_scoreboard", {28'd0, bus.digit}, {28'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NC*DW-1:0] pack(input int s[NC]);
    logic [NC*DW-1:0] v;
    for (int i = 0; i < NC; i++) v[i*DW +: DW] = 16'(s[i]);
    return v;
  endfunction

  // From IDLE: accept image, run both layers, end in the first ARGMAX cycle.
  task automatic start_img(input logic [NC*DW-1:0] sc, input int l1_lat, input int l2_lat,
                           input bit early_l2);
    chk("idle_img_ready", bus.img_ready, 1);
    bus.l2_scores = sc;
    bus.img_valid = 1'b1;
    next();
    bus.img_valid = 1'b0;
    chk("l1_en_after_accept", bus.l1_enable, 1);
    chk("img_ready_low_in_run", bus.img_ready, 0);
    chk("busy_in_run", bus.busy, 1);
    for (int k = 1; k < l1_lat; k++) begin
      bus.l2_done = early_l2 && (k == 5);
      next();
    end
    bus.l2_done = 1'b0;
    if (early_l2) begin
      chk("l2_done_ignored_l2_en", bus.l2_enable, 0);
      chk("l2_done_ignored_l1_en", bus.l1_enable, 1);
    end
    bus.l1_done = 1'b1;
    next();
    bus.l1_done = 1'b0;
    chk("l2_en_after_l1_done", bus.l2_enable, 1);
    chk("l1_en_held_in_l2", bus.l1_enable, 1);
    for (int k = 1; k < l2_lat; k++) next();
    bus.l2_done = 1'b1;
    next();
    bus.l2_done = 1'b0;
  endtask

  task automatic finish_img(input logic [3:0] exp, input int hold);
    int n;
    n = 1;
    while (!bus.digit_valid && n < 64) begin
      next();
      n++;
    end
    chk("digit_valid_latency", n, NC + 1);
    for (int k = 0; k < hold; k++) begin
      bus.img_valid = (k == 10);
      chk("digit_hold", {27'd0, bus.digit_valid, bus.digit}, {27'd0, 1'b1, exp});
      next();
    end
    bus.img_valid = 1'b0;
    chk("img_ready_low_in_out", bus.img_ready, 0);
    chk("digit_before_hs", {27'd0, bus.digit_valid, bus.digit}, {27'd0, 1'b1, exp});
    bus.digit_ready = 1'b1;
    next();
    bus.digit_ready = 1'b0;
    chk("clear_after_hs", bus.layer_clear, 1);
    chk("digit_valid_drop", bus.digit_valid, 0);
    next();
    chk("img_ready_after_clear", bus.img_ready, 1);
  endtask

  task automatic run_img(input int s[NC], input logic [3:0] exp, input int hold,
                         input bit early_l2);
    exp_q.push_back(exp);
    start_img(pack(s), 40, 20, early_l2);
    finish_img(exp, hold);
  endtask

  initial begin
    int v1[NC] = '{3, -7, 12, 0, 5, 12, -1, 2, 8, 9};
    int v2[NC] = '{-5, -3, -9, -3, -100, -4, 4, -7, -6, -2};
    int v3[NC] = '{7, 7, 7, 7, 7, 7, 7, 7, 7, 7};
    int v4[NC] = '{32767, -32768, 100, 32767, 0, 0, 0, 0, 0, 0};
    int v5[NC] = '{-9, -8, -30, -1, -5, -1, -7, -2, -3, -4};
    int v6[NC] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    checks = 0;
    errors = 0;
    reset = 1'b0;
    bus.img_valid   = 1'b0;
    bus.l1_done     = 1'b0;
    bus.l2_done     = 1'b0;
    bus.digit_ready = 1'b0;
    bus.l2_scores   = '0;
    repeat (3) next();
    chk("rst_layer_clear", bus.layer_clear, 1);
    chk("rst_busy", bus.busy, 1);
    chk("rst_img_ready", bus.img_ready, 0);
    chk("rst_enables", {bus.l1_enable, bus.l2_enable}, 0);
    chk("rst_digit_valid", bus.digit_valid, 0);
    chk("rst_timeout", bus.timeout, 0);
    chk("rst_digit", bus.digit, 0);
    reset = 1'b1;
    next();
    chk("rel_img_ready", bus.img_ready, 1);
    chk("rel_busy", bus.busy, 0);
    chk("rel_layer_clear", bus.layer_clear, 0);

    run_img(v1, 4'd2, 0, 1'b0);
    run_img(v2, 4'd6, 30, 1'b1);
    run_img(v3, 4'd0, 3, 1'b0);
    run_img(v4, 4'd0, 0, 1'b0);
    run_img(v5, 4'd3, 12, 1'b0);
    chk("timeout_idle", bus.timeout, 0);

    // Asynchronous reset in the middle of ARGMAX.
    start_img(pack(v1), 10, 5, 1'b0);
    next();
    next();
    chk("in_argmax", {bus.l1_enable, bus.l2_enable}, 2'b11);
    reset = 1'b0;
    #1;
    chk("mid_rst_layer_clear", bus.layer_clear, 1);
    chk("mid_rst_enables", {bus.l1_enable, bus.l2_enable}, 0);
    chk("mid_rst_busy", bus.busy, 1);
    chk("mid_rst_digit", bus.digit, 0);
    chk("mid_rst_ready_valid", {bus.img_ready, bus.digit_valid}, 0);
    next();
    reset = 1'b1;
    next();
    chk("post_rst_img_ready", bus.img_ready, 1);
    run_img(v6, 4'd7, 2, 1'b0);

`ifdef DENSE_SEQ_TIMEOUT_EN
    bus.img_valid = 1'b1;
    next();
    bus.img_valid = 1'b0;
    for (int k = 1; k < 64; k++) begin
      next();
      if (bus.timeout || !bus.l1_enable) chk("timeout_early", k, 64);
    end
    next();
    chk("timeout_pulse", bus.timeout, 1);
    chk("timeout_clear", bus.layer_clear, 1);
    chk("timeout_no_digit", bus.digit_valid, 0);
    next();
    chk("timeout_one_cycle", bus.timeout, 0);
    chk("timeout_img_ready", bus.img_ready, 1);
`endif

    repeat (2) next();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dense_sequencer.md
# dense_sequencer

Control FSM that runs the fully connected stage of the digit classifier for one pooled image at a time. It accepts a pooled image via a valid/ready handshake, then runs dense layer 1 and dense layer 2 in turn by driving their `enable` inputs and waiting for their `layer_done` outputs. It then serially arg-maxes the layer-2 scores into a 4-bit digit, offers that digit downstream via valid/ready, and clears both layers before accepting the next image.

## Interface
- `N_CLASS`, 10, number of layer-2 scores (classes)
- `DATA_W`, 16, width of each signed layer-2 score
- `TIMEOUT_CYCLES`, 4096, watchdog limit per layer run (used only with `DENSE_SEQ_TIMEOUT_EN`)

- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `img_valid`  in  1  upstream pooled image is valid; upstream holds the image stable until `digit_valid`
- `img_ready`  out  1  sequencer can accept an image
- `l1_enable`  out  1  enable to dense layer 1
- `l1_done`  in  1  layer-1 done
- `l2_enable`  out  1  enable to dense layer 2
- `l2_done`  in  1  layer-2 done
- `layer_clear`  out  1  active-high synchronous clear, driven to both layers' reset inputs
- `l2_scores`  in  `N_CLASS*DATA_W`  packed signed scores; class i occupies bits [i*DATA_W +: DATA_W]
- `digit`  out  4  winning class index
- `digit_valid`  out  1  `digit` is valid
- `digit_ready`  in  1  downstream accepts the digit
- `busy`  out  1  high whenever state is not IDLE
- `timeout`  out  1  one-cycle pulse when a layer run is aborted

## Operation
- States: CLEAR, IDLE, L1_RUN, L2_RUN, ARGMAX, OUT.
- All outputs are registered and Moore-decoded from the state.
- While `reset` is low, the state is CLEAR.
- CLEAR:
  - `layer_clear`=1, both enables 0.
  - Lasts exactly 1 cycle, then goes to IDLE.
- IDLE:
  - `img_ready`=1.
  - `img_valid` high at an edge moves to L1_RUN.
- L1_RUN:
  - `l1_enable`=1.
  - `l1_done` high moves to L2_RUN.
  - `l2_done` is ignored in this state.
- L2_RUN:
  - `l1_enable`=1 and `l2_enable`=1, so layer-1 outputs stay held.
  - `l2_done` high moves to ARGMAX.
- ARGMAX:
  - Both enables stay 1.
  - Index counter i runs 0..N_CLASS-1, one score per cycle.
  - Running max is initialised from score 0.
  - Score i replaces the max only if strictly greater in signed compare, so a tie keeps the lowest index.
  - After i = N_CLASS-1, the winner is latched into `digit` and the state moves to OUT.
- OUT:
  - `digit_valid`=1. `digit` and `digit_valid` stay stable until `digit_ready` is high at an edge.
  - On that edge, moves to CLEAR.
- `digit` keeps its last value outside OUT; the value is meaningful only while `digit_valid` is high.
- `digit_ready` has no effect outside OUT.
- `img_valid` has no effect outside IDLE.

## Timing
- Reset values:
  - `layer_clear`=1, `busy`=1
  - `img_ready`, `l1_enable`, `l2_enable`, `digit_valid`, `timeout` = 0
  - `digit`=0
- First edge after `reset` rises: CLEAR→IDLE, and `img_ready` goes to 1.
- Image accepted at edge k: `l1_enable`=1 from cycle k+1.
- `l1_done` sampled at edge t: `l2_enable`=1 from cycle t+1.
- `l2_done` sampled at edge t: ARGMAX occupies cycles t+1 .. t+N_CLASS, and `digit_valid`=1 from cycle t+N_CLASS+1.
- OUT→CLEAR→IDLE: the next `img_ready` comes 2 cycles after the digit handshake.
- `reset` low in any state: immediate asynchronous return to CLEAR with reset values. The ARGMAX counter and max register are zeroed.

## Configuration
- `DENSE_SEQ_TIMEOUT_EN` defined:
  - A cycle counter is zeroed on entry to L1_RUN and on entry to L2_RUN.
  - If it reaches `TIMEOUT_CYCLES` without the matching done, the FSM goes to CLEAR and `timeout` pulses for 1 cycle (the CLEAR cycle).
  - No digit is produced for that image.
- `DENSE_SEQ_TIMEOUT_EN` undefined:
  - The counter is not built, and the run states wait indefinitely for done.
  - `timeout` is tied to 0.

## Test plan
- Reset release → `layer_clear`=1 for 1 cycle, then `img_ready`=1, `busy`=0.
- Normal run: `img_valid` at edge 5, `l1_done` 40 cycles later, `l2_done` 20 cycles after that, scores {3,-7,12,0,5,12,-1,2,8,9}:
  - `digit`=2 (tie at 12 keeps the lowest index).
  - `digit_valid` rises exactly 11 cycles after `l2_done` is sampled.
- Backpressure: hold `digit_ready`=0 for 30 cycles → `digit`/`digit_valid` stable throughout. A `img_valid` pulse in that window is ignored (`img_ready`=0).
- Ordering: pulse `l2_done` during L1_RUN → ignored, FSM stays in L1_RUN. A later `l1_done` then advances it to L2_RUN.
- Mid-run reset: drive `reset` low during ARGMAX → all outputs take reset values within the same cycle. After release, a full new run produces the correct digit.
- With `DENSE_SEQ_TIMEOUT_EN` and `TIMEOUT_CYCLES`=64, never assert `l1_done` → `timeout` pulses at cycle 64 after L1_RUN entry, `layer_clear` pulses, no `digit_valid`, then `img_ready`=1.
